// File: rtl/code_lock_if.sv
// Key/timer inputs and status outputs of the code lock controller.
// The bench drives through master; the controller uses slave.
interface code_lock_if #(
  parameter int NUM_KEYS  = 5,
  parameter int CODE_LEN  = 4,
  parameter int MAX_TRIES = 3
);
  localparam int PW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);

  logic                tick;
  logic [NUM_KEYS-1:0] key;
  logic                relock;
  logic                prog;
  logic                unlock;
  logic                lock;
  logic                alarm;
  logic [2:0]          state;
  logic [PW-1:0]       pos;
  logic [FW-1:0]       fail_cnt;

  modport master (
    output tick, key, relock, prog,
    input  unlock, lock, alarm, state, pos, fail_cnt
  );

  modport slave (
    input  tick, key, relock, prog,
    output unlock, lock, alarm, state, pos, fail_cnt
  );
endinterface

// File: rtl/code_lock_ctrl.sv
// Parametrised keypad code lock with lockout, entry timeout,
// auto-relock and in-field code reprogramming.
module code_lock_ctrl #(
  parameter int NUM_KEYS      = 5,
  parameter int CODE_LEN      = 4,
  parameter int KEY_W         = $clog2(NUM_KEYS),
  parameter logic [CODE_LEN*KEY_W-1:0] DEFAULT_CODE = 12'h819,
  parameter int MAX_TRIES     = 3,
  parameter int LOCKOUT_TICKS = 30,
  parameter int TIMEOUT_TICKS = 10,
  parameter int RELOCK_TICKS  = 20
) (
  input logic       clk,
  input logic       reset,
  code_lock_if.slave bus
);
  localparam int PW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int CW = CODE_LEN * KEY_W;
  localparam int T1 = (LOCKOUT_TICKS > TIMEOUT_TICKS) ?
                      LOCKOUT_TICKS : TIMEOUT_TICKS;
  localparam int T2 = (T1 > RELOCK_TICKS) ? T1 : RELOCK_TICKS;
  localparam int TW = (T2 < 1) ? 1 : $clog2(T2 + 1);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_UNLOCKED = 3'd1,
    S_PROG     = 3'd2,
    S_LOCKOUT  = 3'd3
  } state_t;

  // {unlock, lock, alarm} for a given state
  function automatic logic [2:0] flg(state_t s);
    return {s == S_UNLOCKED || s == S_PROG,
            s == S_LOCKED || s == S_LOCKOUT,
            s == S_LOCKOUT};
  endfunction

  state_t              st;
  logic [2:0]          fl;
  logic [NUM_KEYS-1:0] key_q;
  logic [PW-1:0]       pos;
  logic [FW-1:0]       fcnt;
  logic [TW-1:0]       tmr;
  logic                bad;
  logic [CW-1:0]       code;
  logic [CW-1:0]       shadow;

  logic [NUM_KEYS-1:0] press;
  logic                any;
  logic                one_hot;
  logic [KEY_W-1:0]    digit;
  logic [KEY_W-1:0]    cur;
  logic [CW-1:0]       shadow_w;
  logic                bad_n;
  logic                last;
  logic                fc_top;
  logic [31:0]         tnext;
  logic                to_hit;
  logic                lo_hit;
  logic                rl_hit;

  assign press   = bus.key & ~key_q;
  assign any     = |press;
  assign one_hot = $onehot(press);

  always_comb begin
    digit = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (press[i]) digit = KEY_W'(i);
  end

  always_comb begin
    cur      = code[32'(pos)*KEY_W +: KEY_W];
    shadow_w = shadow;
    shadow_w[32'(pos)*KEY_W +: KEY_W] = digit;
  end

  assign bad_n  = bad | ~one_hot | (digit != cur);
  assign last   = (32'(pos) == 32'(CODE_LEN - 1));
  assign fc_top = (32'(fcnt) + 32'd1 == 32'(MAX_TRIES));

  // a tick that would bring the count to its limit fires now
  assign tnext  = 32'(tmr) + 32'd1;
  assign to_hit = bus.tick && tnext >= 32'(TIMEOUT_TICKS);
  assign lo_hit = bus.tick && tnext >= 32'(LOCKOUT_TICKS);
  assign rl_hit = bus.tick && tnext >= 32'(RELOCK_TICKS);

  always_ff @(posedge clk) begin
    key_q <= bus.key;
    if (reset) begin
      st     <= S_LOCKED;
      fl     <= flg(S_LOCKED);
      key_q  <= '0;
      pos    <= '0;
      fcnt   <= '0;
      tmr    <= '0;
      bad    <= 1'b0;
      code   <= DEFAULT_CODE;
      shadow <= '0;
    end else begin
      unique case (st)
        S_LOCKED: begin
          if (any) begin
            tmr <= '0;
            if (last) begin
              pos <= '0;
              bad <= 1'b0;
              if (!bad_n) begin
                st   <= S_UNLOCKED;
                fl   <= flg(S_UNLOCKED);
                fcnt <= '0;
              end else if (fc_top) begin
                st <= S_LOCKOUT;
                fl <= flg(S_LOCKOUT);
              end else begin
                fcnt <= fcnt + FW'(1);
              end
            end else begin
              pos <= pos + PW'(1);
              bad <= bad_n;
            end
          end else if (pos != '0 && bus.tick) begin
            if (to_hit) begin
              pos <= '0;
              bad <= 1'b0;
              tmr <= '0;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
        end
        S_UNLOCKED: begin
          if (bus.relock) begin
            st  <= S_LOCKED;
            fl  <= flg(S_LOCKED);
            tmr <= '0;
          end else if (bus.prog) begin
            st  <= S_PROG;
            fl  <= flg(S_PROG);
            pos <= '0;
            tmr <= '0;
          end else if (any) begin
            tmr <= '0;
          end else if (bus.tick && RELOCK_TICKS != 0) begin
            if (rl_hit) begin
              st  <= S_LOCKED;
              fl  <= flg(S_LOCKED);
              tmr <= '0;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
        end
        S_PROG: begin
          if (bus.relock || !bus.prog) begin
            st  <= S_LOCKED;
            fl  <= flg(S_LOCKED);
            pos <= '0;
            tmr <= '0;
          end else if (any) begin
            tmr <= '0;
            if (one_hot) begin
              if (last) begin
                code <= shadow_w;
                st   <= S_UNLOCKED;
                fl   <= flg(S_UNLOCKED);
                pos  <= '0;
              end else begin
                shadow <= shadow_w;
                pos    <= pos + PW'(1);
              end
            end
          end else if (bus.tick) begin
            if (to_hit) begin
              st  <= S_LOCKED;
              fl  <= flg(S_LOCKED);
              pos <= '0;
              tmr <= '0;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
        end
        S_LOCKOUT: begin
          if (bus.tick) begin
            if (lo_hit) begin
              st   <= S_LOCKED;
              fl   <= flg(S_LOCKED);
              fcnt <= '0;
              tmr  <= '0;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
        end
        default: begin
          st <= S_LOCKED;
          fl <= flg(S_LOCKED);
        end
      endcase
    end
  end

  assign bus.state    = st;
  assign bus.unlock   = fl[2];
  assign bus.lock     = fl[1];
  assign bus.alarm    = fl[0];
  assign bus.pos      = pos;
  assign bus.fail_cnt = fcnt;
endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed-vector bench for code_lock_ctrl with default parameters.
module tb_code_lock_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  code_lock_if b();

  code_lock_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  task automatic press(input int k);
    @(negedge clk);
    b.key = '0;
    b.key[k] = 1'b1;
    @(negedge clk);
    b.key = '0;
  endtask

  task automatic enter(input int d0, input int d1,
                       input int d2, input int d3);
    press(d0);
    press(d1);
    press(d2);
    press(d3);
  endtask

  task automatic ticks(input int n);
    b.tick = 1'b1;
    repeat (n) @(negedge clk);
    b.tick = 1'b0;
  endtask

  task automatic do_reset;
    b.key = '0;
    b.relock = 1'b0;
    b.prog = 1'b0;
    b.tick = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    b.key = '0;
    b.relock = 1'b0;
    b.prog = 1'b0;
    b.tick = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({b.state, b.lock, b.unlock, b.alarm, b.pos, b.fail_cnt}
        !== {3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset got st=%0d lk=%b ul=%b al=%b pos=%0d fc=%0d want 0 1 0 0 0 0",
               b.state, b.lock, b.unlock, b.alarm, b.pos, b.fail_cnt);
    end
  endtask

  task automatic test_correct_code;
    do_reset();
    press(1);
    press(3);
    checks++;
    if (b.pos !== 3'd2) begin
      errors++;
      $display("FAIL ok_pos got %0d want 2", b.pos);
    end
    press(0);
    press(4);
    checks++;
    if ({b.state, b.unlock, b.lock, b.fail_cnt, b.pos}
        !== {3'd1, 1'b1, 1'b0, 2'd0, 3'd0}) begin
      errors++;
      $display("FAIL ok_code got st=%0d ul=%b lk=%b fc=%0d pos=%0d want 1 1 0 0 0",
               b.state, b.unlock, b.lock, b.fail_cnt, b.pos);
    end
  endtask

  task automatic test_lockout;
    do_reset();
    enter(2, 2, 2, 2);
    checks++;
    if ({b.state, b.fail_cnt} !== {3'd0, 2'd1}) begin
      errors++;
      $display("FAIL lo_try1 got st=%0d fc=%0d want 0 1", b.state, b.fail_cnt);
    end
    enter(2, 2, 2, 2);
    checks++;
    if ({b.state, b.fail_cnt} !== {3'd0, 2'd2}) begin
      errors++;
      $display("FAIL lo_try2 got st=%0d fc=%0d want 0 2", b.state, b.fail_cnt);
    end
    enter(2, 2, 2, 2);
    checks++;
    if ({b.state, b.alarm, b.lock} !== {3'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL lo_enter got st=%0d al=%b lk=%b want 3 1 1",
               b.state, b.alarm, b.lock);
    end
    enter(1, 3, 0, 4);
    checks++;
    if ({b.state, b.lock, b.unlock} !== {3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lo_keys got st=%0d lk=%b ul=%b want 3 1 0",
               b.state, b.lock, b.unlock);
    end
    ticks(29);
    checks++;
    if (b.state !== 3'd3) begin
      errors++;
      $display("FAIL lo_29 got st=%0d want 3", b.state);
    end
    ticks(1);
    checks++;
    if ({b.state, b.fail_cnt, b.alarm} !== {3'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL lo_exit got st=%0d fc=%0d al=%b want 0 0 0",
               b.state, b.fail_cnt, b.alarm);
    end
    enter(1, 3, 0, 4);
    checks++;
    if (b.state !== 3'd1) begin
      errors++;
      $display("FAIL lo_after got st=%0d want 1", b.state);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    press(1);
    press(3);
    ticks(9);
    checks++;
    if (b.pos !== 3'd2) begin
      errors++;
      $display("FAIL to_9 got pos=%0d want 2", b.pos);
    end
    ticks(1);
    checks++;
    if ({b.pos, b.fail_cnt} !== {3'd0, 2'd0}) begin
      errors++;
      $display("FAIL to_10 got pos=%0d fc=%0d want 0 0", b.pos, b.fail_cnt);
    end
    enter(0, 4, 1, 3);
    checks++;
    if ({b.state, b.fail_cnt} !== {3'd0, 2'd1}) begin
      errors++;
      $display("FAIL to_after got st=%0d fc=%0d want 0 1", b.state, b.fail_cnt);
    end
  endtask

  task automatic test_reprogram;
    do_reset();
    enter(1, 3, 0, 4);
    b.prog = 1'b1;
    @(negedge clk);
    checks++;
    if ({b.state, b.unlock, b.pos} !== {3'd2, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL pg_enter got st=%0d ul=%b pos=%0d want 2 1 0",
               b.state, b.unlock, b.pos);
    end
    enter(4, 4, 2, 0);
    checks++;
    if ({b.state, b.pos} !== {3'd1, 3'd0}) begin
      errors++;
      $display("FAIL pg_commit got st=%0d pos=%0d want 1 0", b.state, b.pos);
    end
    b.prog = 1'b0;
    b.relock = 1'b1;
    @(negedge clk);
    b.relock = 1'b0;
    checks++;
    if ({b.state, b.lock} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL pg_relock got st=%0d lk=%b want 0 1", b.state, b.lock);
    end
    enter(1, 3, 0, 4);
    checks++;
    if ({b.state, b.fail_cnt} !== {3'd0, 2'd1}) begin
      errors++;
      $display("FAIL pg_old got st=%0d fc=%0d want 0 1", b.state, b.fail_cnt);
    end
    enter(4, 4, 2, 0);
    checks++;
    if ({b.state, b.fail_cnt} !== {3'd1, 2'd0}) begin
      errors++;
      $display("FAIL pg_new got st=%0d fc=%0d want 1 0", b.state, b.fail_cnt);
    end
    do_reset();
    enter(1, 3, 0, 4);
    checks++;
    if (b.state !== 3'd1) begin
      errors++;
      $display("FAIL pg_rst got st=%0d want 1", b.state);
    end
  endtask

  task automatic test_abort_relock;
    do_reset();
    enter(1, 3, 0, 4);
    b.prog = 1'b1;
    @(negedge clk);
    press(4);
    press(4);
    checks++;
    if ({b.state, b.pos} !== {3'd2, 3'd2}) begin
      errors++;
      $display("FAIL ab_mid got st=%0d pos=%0d want 2 2", b.state, b.pos);
    end
    b.relock = 1'b1;
    @(negedge clk);
    b.relock = 1'b0;
    b.prog = 1'b0;
    checks++;
    if ({b.state, b.pos} !== {3'd0, 3'd0}) begin
      errors++;
      $display("FAIL ab_abort got st=%0d pos=%0d want 0 0", b.state, b.pos);
    end
    enter(1, 3, 0, 4);
    checks++;
    if (b.state !== 3'd1) begin
      errors++;
      $display("FAIL ab_old got st=%0d want 1", b.state);
    end
    ticks(19);
    checks++;
    if (b.state !== 3'd1) begin
      errors++;
      $display("FAIL rl_19 got st=%0d want 1", b.state);
    end
    ticks(1);
    checks++;
    if ({b.state, b.lock, b.unlock} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rl_20 got st=%0d lk=%b ul=%b want 0 1 0",
               b.state, b.lock, b.unlock);
    end
  endtask

  task automatic test_edge;
    do_reset();
    @(negedge clk);
    b.key = 5'b00011;
    @(negedge clk);
    b.key = '0;
    press(3);
    press(0);
    press(4);
    checks++;
    if ({b.state, b.fail_cnt} !== {3'd0, 2'd1}) begin
      errors++;
      $display("FAIL multi got st=%0d fc=%0d want 0 1", b.state, b.fail_cnt);
    end
    @(negedge clk);
    b.key[3] = 1'b1;
    repeat (50) @(negedge clk);
    b.key = '0;
    @(negedge clk);
    checks++;
    if (b.pos !== 3'd1) begin
      errors++;
      $display("FAIL hold got pos=%0d want 1", b.pos);
    end
    press(0);
    checks++;
    if (b.pos !== 3'd2) begin
      errors++;
      $display("FAIL mid_pos got pos=%0d want 2", b.pos);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({b.state, b.lock, b.unlock, b.alarm, b.pos, b.fail_cnt}
        !== {3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0}) begin
      errors++;
      $display("FAIL mid_rst got st=%0d lk=%b ul=%b al=%b pos=%0d fc=%0d want 0 1 0 0 0 0",
               b.state, b.lock, b.unlock, b.alarm, b.pos, b.fail_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_lockout();
    test_timeout();
    test_reprogram();
    test_abort_relock();
    test_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
